// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared constants for the RV32M divide group.
//   - R-type M-extension opcode / funct7
//   - DIV/DIVU/REM/REMU funct3 codes
//   - stall request levels used on the ctrl stall path
package div_seq_pkg;

   localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] INST_DIV  = 3'b100;
   localparam logic [2:0] INST_DIVU = 3'b101;
   localparam logic [2:0] INST_REM  = 3'b110;
   localparam logic [2:0] INST_REMU = 3'b111;

   localparam logic STALL_ENABLE  = 1'b1;
   localparam logic STALL_DISABLE = 1'b0;

   // funct3[0] clear selects the signed variants (DIV/REM).
   function automatic logic op_is_signed(input logic [2:0] funct3);
      return !funct3[0];
   endfunction

   // funct3[1] set selects the remainder variants (REM/REMU).
   function automatic logic op_is_rem(input logic [2:0] funct3);
      return funct3[1];
   endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: exe <-> divide sequencer handshake.
//   master (exe side): drives start/funct3/operands/cancel, sees result,
//                      ready, busy and the stall request.
//   slave  (divider):  the reverse.
interface div_seq_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start_i;
   logic [2:0]            funct3_i;
   logic [DATA_WIDTH-1:0] dividend_i;
   logic [DATA_WIDTH-1:0] divisor_i;
   logic                  cancel_i;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  ready_o;
   logic                  busy_o;
   logic                  stall_req_o;

   modport master (
      output start_i, funct3_i, dividend_i, divisor_i, cancel_i,
      input  result_o, ready_o, busy_o, stall_req_o
   );

   modport slave (
      input  start_i, funct3_i, dividend_i, divisor_i, cancel_i,
      output result_o, ready_o, busy_o, stall_req_o
   );
endinterface

// File: rtl/div_seq.sv
// div_seq: iterative restoring divider for DIV/DIVU/REM/REMU.
//   clk_i  : core clock, all state on rising edge
//   rst_i  : synchronous active-high reset
//   bus    : div_seq_if slave modport
//            start_i/funct3_i/dividend_i/divisor_i sampled in IDLE only,
//            cancel_i abandons any operation, ready_o pulses one cycle
//            with result_o, stall_req_o freezes the pipe up to exe.
// One quotient bit per cycle: DATA_WIDTH cycles in CALC, then one DONE cycle.
// Divide-by-zero and signed overflow skip CALC and go straight to DONE.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic      clk_i,
   input  logic      rst_i,
   div_seq_if.slave  bus
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    rem_q, rem_d;     // partial remainder, one guard bit
   logic [W-1:0]  qd_q, qd_d;       // dividend shifts out, quotient shifts in
   logic [W-1:0]  dvs_q, dvs_d;     // divisor magnitude
   logic          is_rem_q, is_rem_d;
   logic          neg_q_q, neg_q_d; // negate quotient on exit
   logic          neg_r_q, neg_r_d; // negate remainder on exit
   logic [W-1:0]  result_q, result_d;

   // ---------------------------------------------------------------
   // Operand decode (only meaningful in IDLE)
   // ---------------------------------------------------------------
   logic         op_signed, op_rem, a_neg, b_neg, div_zero, ovf, accept;
   logic [W-1:0] a_mag, b_mag;

   always_comb begin
      op_signed = op_is_signed(bus.funct3_i);
      op_rem    = op_is_rem(bus.funct3_i);
      a_neg     = op_signed & bus.dividend_i[W-1];
      b_neg     = op_signed & bus.divisor_i[W-1];
      a_mag     = a_neg ? (~bus.dividend_i + W'(1)) : bus.dividend_i;
      b_mag     = b_neg ? (~bus.divisor_i  + W'(1)) : bus.divisor_i;
      div_zero  = (bus.divisor_i == '0);
      ovf       = op_signed & (bus.dividend_i == {1'b1, {(W-1){1'b0}}})
                            & (&bus.divisor_i);
      accept    = (state_q == S_IDLE) & bus.start_i & !bus.cancel_i;
   end

   // ---------------------------------------------------------------
   // Restoring step
   // ---------------------------------------------------------------
   logic [W:0]   rem_sh, diff, rem_nx;
   logic         q_bit;
   logic [W-1:0] qd_nx, q_fix, r_fix;

   always_comb begin
      rem_sh = {rem_q[W-1:0], qd_q[W-1]};
      diff   = rem_sh - {1'b0, dvs_q};
      q_bit  = !diff[W];               // no borrow -> divisor fits
      rem_nx = q_bit ? diff : rem_sh;
      qd_nx  = {qd_q[W-2:0], q_bit};
      q_fix  = neg_q_q ? (~qd_nx + W'(1)) : qd_nx;
      r_fix  = neg_r_q ? (~rem_nx[W-1:0] + W'(1)) : rem_nx[W-1:0];
   end

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         qd_q     <= '0;
         dvs_q    <= '0;
         is_rem_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         qd_q     <= qd_d;
         dvs_q    <= dvs_d;
         is_rem_q <= is_rem_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         result_q <= result_d;
      end
   end

   // ---------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = (div_zero | ovf) ? S_DONE : S_CALC;
         S_CALC: if (cnt_q == CNT_LAST) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (bus.cancel_i) state_d = S_IDLE;
   end

   // ---------------------------------------------------------------
   // Datapath next values
   // ---------------------------------------------------------------
   always_comb begin
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      qd_d     = qd_q;
      dvs_d    = dvs_q;
      is_rem_d = is_rem_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      result_d = result_q;

      if (accept) begin
         is_rem_d = op_rem;
         neg_q_d  = a_neg ^ b_neg;
         neg_r_d  = a_neg;
         cnt_d    = '0;
         if (div_zero) begin
            result_d = op_rem ? bus.dividend_i : '1;
         end else if (ovf) begin
            result_d = op_rem ? '0 : {1'b1, {(W-1){1'b0}}};
         end else begin
            rem_d = '0;
            qd_d  = a_mag;
            dvs_d = b_mag;
         end
      end else if (state_q == S_CALC && !bus.cancel_i) begin
         rem_d = rem_nx;
         qd_d  = qd_nx;
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            result_d = is_rem_q ? r_fix : q_fix;
         end
      end

      if (bus.cancel_i) cnt_d = '0;
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   always_comb begin
      bus.result_o    = result_q;
      bus.ready_o     = (state_q == S_DONE) & !bus.cancel_i;
      bus.busy_o      = (state_q == S_CALC) | (state_q == S_DONE);
      // Dropping stall in DONE lets the pipe advance and take the result.
      bus.stall_req_o = (accept | (state_q == S_CALC)) ? STALL_ENABLE
                                                       : STALL_DISABLE;
   end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   div_seq_if #(.DATA_WIDTH(32)) bus ();

   div_seq #(.DATA_WIDTH(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   // Drives one divide starting in the current cycle (called just after a
   // rising edge) and measures it; returns just after the edge that ends
   // the DONE cycle.
   task automatic do_div(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit release_start,
                         output int lat, output logic [31:0] res,
                         output int stall_low, output logic stall_done);
      bus.start_i    = 1'b1;
      bus.funct3_i   = f;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      lat = -1; res = '0; stall_low = 0; stall_done = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus.ready_o) begin
            lat = c; res = bus.result_o; stall_done = bus.stall_req_o;
            break;
         end
         if (!bus.stall_req_o) stall_low++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (release_start) bus.start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (bus.result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result_o); end
      n_chk++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.ready_o); end
      n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
      n_chk++; if (bus.stall_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall_req_o); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_divu_basic();
      int lat, sl; logic [31:0] res; logic sd;
      do_div(3'b101, 32'd100, 32'd7, 1'b1, lat, res, sl, sd);
      n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got %0d want 33", lat); end
      n_chk++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result got %h want %h", res, 32'd14); end
      n_chk++; if (sl !== 0) begin n_fail++; $display("FAIL divu_stall_held got %0d low cycles want 0", sl); end
      n_chk++; if (sd !== 1'b0) begin n_fail++; $display("FAIL divu_stall_in_done got %b want 0", sd); end
      @(negedge clk);
      n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL divu_busy_after got %b want 0", bus.busy_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_vectors();
      vec_t v[12];
      int lat, sl; logic [31:0] res; logic sd;
      v[0]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33}; // REM -7/2
      v[1]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33}; // DIV -7/2
      v[2]  = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33}; // DIV 7/-2
      v[3]  = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33}; // REM 7/-2
      v[4]  = '{3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33};
      v[5]  = '{3'b111, 32'hFFFF_FFFF, 32'h10,       32'hF,         33};
      v[6]  = '{3'b101, 32'd5,         32'd10,       32'd0,         33};
      v[7]  = '{3'b101, 32'h1234,      32'd0,        32'hFFFF_FFFF, 1};  // /0
      v[8]  = '{3'b111, 32'h1234,      32'd0,        32'h1234,      1};
      v[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1}; // overflow
      v[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
      v[11] = '{3'b110, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1};  // REM -5/0
      for (int i = 0; i < 12; i++) begin
         do_div(v[i].f, v[i].a, v[i].b, 1'b1, lat, res, sl, sd);
         n_chk++; if (res !== v[i].exp) begin n_fail++; $display("FAIL vec%0d_result got %h want %h", i, res, v[i].exp); end
         n_chk++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, v[i].lat); end
      end
   endtask

   task automatic test_cancel();
      int lat, sl, rdy; logic [31:0] res; logic sd;
      rdy = 0;
      bus.start_i = 1'b1; bus.funct3_i = 3'b101;
      bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.ready_o) rdy++;
         @(posedge clk); #1;
      end
      bus.cancel_i = 1'b1; bus.start_i = 1'b0;   // cycle 10
      @(negedge clk);
      if (bus.ready_o) rdy++;
      @(posedge clk); #1;
      bus.cancel_i = 1'b0;                        // cycle 11
      n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got %b want 0", bus.busy_o); end
      n_chk++; if (bus.stall_req_o !== 1'b0) begin n_fail++; $display("FAIL cancel_stall got %b want 0", bus.stall_req_o); end
      n_chk++; if (rdy !== 0) begin n_fail++; $display("FAIL cancel_no_ready got %0d pulses want 0", rdy); end
      do_div(3'b101, 32'd9, 32'd3, 1'b1, lat, res, sl, sd);
      n_chk++; if (res !== 32'd3) begin n_fail++; $display("FAIL cancel_restart_result got %h want 3", res); end
      n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL cancel_restart_latency got %0d want 33", lat); end
      // cancel wins over start in IDLE
      bus.start_i = 1'b1; bus.cancel_i = 1'b1;
      bus.funct3_i = 3'b101; bus.dividend_i = 32'd8; bus.divisor_i = 32'd0;
      @(negedge clk);
      n_chk++; if (bus.stall_req_o !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_stall got %b want 0", bus.stall_req_o); end
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.cancel_i = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_start busy %b ready %b want 0 0", bus.busy_o, bus.ready_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bus.start_i = 1'b1; bus.funct3_i = 3'b100;
      bus.dividend_i = 32'd1000; bus.divisor_i = 32'd7;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;                                 // cycle 20
      @(posedge clk); #1;
      bus.start_i = 1'b0; rst = 1'b0;             // cycle 21
      #1;
      n_chk++; if (bus.result_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", bus.result_o); end
      n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy_o); end
      n_chk++; if (bus.ready_o !== 1'b0 || bus.stall_req_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_stall got %b %b want 0 0", bus.ready_o, bus.stall_req_o); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, sl1, sl2; logic [31:0] r1, r2; logic sd1, sd2;
      do_div(3'b101, 32'd1000, 32'd7, 1'b0, lat1, r1, sl1, sd1);
      do_div(3'b111, 32'd1000, 32'd7, 1'b1, lat2, r2, sl2, sd2);
      n_chk++; if (r1 !== 32'd142) begin n_fail++; $display("FAIL b2b_first_result got %h want %h", r1, 32'd142); end
      n_chk++; if (lat1 !== 33) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 33", lat1); end
      n_chk++; if (r2 !== 32'd6) begin n_fail++; $display("FAIL b2b_second_result got %h want 6", r2); end
      n_chk++; if (lat2 !== 33) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 33", lat2); end
      n_chk++; if (sl1 + sl2 !== 0) begin n_fail++; $display("FAIL b2b_stall got %0d low cycles want 0", sl1 + sl2); end
   endtask

   initial begin
      bus.start_i = 1'b0; bus.funct3_i = 3'b000;
      bus.dividend_i = '0; bus.divisor_i = '0; bus.cancel_i = 1'b0;
      test_reset();
      test_divu_basic();
      test_vectors();
      test_cancel();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1);
   end

endmodule
